// File: rtl/ddr3_ui_arbiter.sv
// Two-requester round-robin arbiter in front of the MIG native app_* interface.
// Reads are steered back to their issuer through an in-order tag FIFO.
module ddr3_ui_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 512,
    parameter int MASK_WIDTH = 64,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    init_calib_complete,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    input  logic [2*MASK_WIDTH-1:0] req_wmask,
    output logic [1:0]              req_ready,
    output logic [1:0]              rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_tag_err,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [MASK_WIDTH-1:0]   app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic                    grant_r;
    logic                    rd_flag_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [MASK_WIDTH-1:0]   wmask_r;
    logic                    cmd_done_r;
    logic                    wdf_done_r;
    logic                    rr_ptr_r;

    logic                    tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        tag_count_r;

    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic [1:0]              rd_valid_r;
    logic                    tag_err_r;

    logic                    tag_not_full_s;
    logic [1:0]              eligible_s;
    logic                    grant_valid_s;
    logic                    grant_idx_s;
    logic                    cmd_acc_s;
    logic                    wdf_acc_s;
    logic [1:0]              req_ready_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    pop_tag_s;

    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [MASK_WIDTH-1:0]   sel_wmask_s;

    // A read needs a free tag slot; writes only need calibration.
    assign tag_not_full_s = (tag_count_r != CNT_FULL);
    assign eligible_s     = req_valid & {2{init_calib_complete}} &
                            (req_write | {2{tag_not_full_s}});

    // Select the granted requester's request fields
    always_comb begin
        sel_write_s = req_write[0];
        sel_addr_s  = req_addr[0 +: ADDR_WIDTH];
        sel_wdata_s = req_wdata[0 +: DATA_WIDTH];
        sel_wmask_s = req_wmask[0 +: MASK_WIDTH];
        if (grant_idx_s) begin
            sel_write_s = req_write[1];
            sel_addr_s  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata_s = req_wdata[DATA_WIDTH +: DATA_WIDTH];
            sel_wmask_s = req_wmask[MASK_WIDTH +: MASK_WIDTH];
        end else begin
            sel_write_s = req_write[0];
        end
    end

    // Next-state, grant selection and handshake decode
    always_comb begin
        next_state_s  = state_r;
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        cmd_acc_s     = 1'b0;
        wdf_acc_s     = 1'b0;
        req_ready_s   = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    grant_valid_s = 1'b1;
                    if (eligible_s[rr_ptr_r]) begin
                        grant_idx_s = rr_ptr_r;
                    end else begin
                        grant_idx_s = ~rr_ptr_r;
                    end
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cmd_acc_s = !cmd_done_r && app_rdy;
                wdf_acc_s = !wdf_done_r && app_wdf_rdy;
                if ((cmd_done_r || cmd_acc_s) && (wdf_done_r || wdf_acc_s)) begin
                    req_ready_s[grant_r] = 1'b1;
                    next_state_s         = ST_IDLE;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Transaction context: captured on grant, handshake progress tracked in ISSUE
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_r    <= 1'b0;
            rd_flag_r  <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wmask_r    <= {MASK_WIDTH{1'b0}};
            cmd_done_r <= 1'b0;
            wdf_done_r <= 1'b0;
            rr_ptr_r   <= 1'b0;
        end else if (grant_valid_s) begin
            grant_r    <= grant_idx_s;
            rd_flag_r  <= ~sel_write_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            wmask_r    <= sel_wmask_s;
            cmd_done_r <= 1'b0;
            wdf_done_r <= ~sel_write_s;
            rr_ptr_r   <= ~grant_idx_s;
        end else begin
            if (cmd_acc_s) begin
                cmd_done_r <= 1'b1;
            end
            if (wdf_acc_s) begin
                wdf_done_r <= 1'b1;
            end
        end
    end

    // Read data returns in command order, so a FIFO of grant indices is enough.
    assign push_s    = cmd_acc_s && rd_flag_r;
    assign pop_s     = app_rd_data_valid && (tag_count_r != CNT_ZERO);
    assign pop_tag_s = tag_mem_r[rd_ptr_r];

    // Tag FIFO storage, pointers and occupancy
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 1'b0;
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            tag_count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_r;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   tag_count_r <= tag_count_r + CNT_ONE;
                2'b01:   tag_count_r <= tag_count_r - CNT_ONE;
                default: tag_count_r <= tag_count_r;
            endcase
        end
    end

    // Read return steering and sticky orphan-data flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 2'b00;
            tag_err_r  <= 1'b0;
        end else if (pop_s) begin
            rd_data_r  <= app_rd_data;
            rd_valid_r <= pop_tag_s ? 2'b10 : 2'b01;
        end else begin
            rd_valid_r <= 2'b00;
            if (app_rd_data_valid) begin
                tag_err_r <= 1'b1;
            end
        end
    end

    assign app_en       = (state_r == ST_ISSUE) && !cmd_done_r;
    assign app_cmd      = {2'b00, rd_flag_r};
    assign app_addr     = addr_r;
    assign app_wdf_data = wdata_r;
    assign app_wdf_mask = wmask_r;
    assign app_wdf_wren = (state_r == ST_ISSUE) && !wdf_done_r;
    assign app_wdf_end  = app_wdf_wren;
    assign req_ready    = req_ready_s;
    assign rd_valid     = rd_valid_r;
    assign rd_data      = rd_data_r;
    assign rd_tag_err   = tag_err_r;

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Bench for ddr3_ui_arbiter: table of single transactions with handshake
// delays, plus contention, tag-full, calibration and reset sequences.
module tb_ddr3_ui_arbiter;

    localparam int AW = 28;
    localparam int DW = 512;
    localparam int MW = 64;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              init_calib_complete;
    logic [1:0]        req_valid;
    logic [1:0]        req_write;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*MW-1:0]   req_wmask;
    logic [1:0]        req_ready;
    logic [1:0]        rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rd_tag_err;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DW-1:0]     app_wdf_data;
    logic [MW-1:0]     app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [DW-1:0]     app_rd_data;
    logic              app_rd_data_valid;

    ddr3_ui_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag_err(rd_tag_err),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        r;
        logic        wr;
        logic [27:0] addr;
        logic [7:0]  pat;
        logic [63:0] mask;
        int          cmd_dly;
        int          wdf_dly;
        int          exp_n;
        int          exp_en;
        int          exp_wren;
    } txn_t;

    txn_t         tbl [6];
    int           checks   = 0;
    int           failures = 0;
    logic [30:0]  exp_cmd_q [$];
    logic [575:0] exp_wdf_q [$];
    logic [513:0] exp_rd_q  [$];
    logic         model_tag_q [$];
    logic         mdl_rr = 1'b0;

    logic [30:0]  mon_cmd;
    logic [575:0] mon_wdf;
    logic [513:0] mon_rd;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=event want=none", name);
    endtask

    // Scoreboard: every accepted command, write beat and read return is popped and compared
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (app_en && app_rdy) begin
                if (exp_cmd_q.size() == 0) unexpected("unexpected_cmd");
                else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    chk("app_cmd_addr", 576'({app_cmd, app_addr}), 576'(mon_cmd));
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("wdf_end", 576'(app_wdf_end), 576'(1'b1));
                if (exp_wdf_q.size() == 0) unexpected("unexpected_wdf");
                else begin
                    mon_wdf = exp_wdf_q.pop_front();
                    chk("wdf_data_mask", {app_wdf_data, app_wdf_mask}, mon_wdf);
                end
            end
            if (rd_valid != 2'b00) begin
                if (exp_rd_q.size() == 0) unexpected("unexpected_rd_valid");
                else begin
                    mon_rd = exp_rd_q.pop_front();
                    chk("rd_valid_data", 576'({rd_valid, rd_data}), 576'(mon_rd));
                end
            end
        end
    end

    task automatic set_req(input logic r, input logic wr, input logic [27:0] addr,
                           input logic [7:0] pat, input logic [63:0] mask);
        req_write[r] = wr;
        req_addr[int'(r)*AW +: AW]  = addr;
        req_wdata[int'(r)*DW +: DW] = {64{pat}};
        req_wmask[int'(r)*MW +: MW] = mask;
    endtask

    task automatic run_txn(input txn_t t);
        int n    = 0;
        int en_c = 0;
        int wr_c = 0;
        bit seen = 1'b0;
        exp_cmd_q.push_back({t.wr ? 3'b000 : 3'b001, t.addr});
        if (t.wr) exp_wdf_q.push_back({{64{t.pat}}, t.mask});
        else      model_tag_q.push_back(t.r);
        mdl_rr = ~t.r;
        set_req(t.r, t.wr, t.addr, t.pat, t.mask);
        req_valid[t.r] = 1'b1;
        app_rdy     = (t.cmd_dly == 0);
        app_wdf_rdy = (t.wdf_dly == 0);
        while (!seen && n < 30) begin
            @(negedge sys_clk);
            n++;
            en_c += int'(app_en);
            wr_c += int'(app_wdf_wren);
            if (req_ready[t.r]) seen = 1'b1;
            @(posedge sys_clk); #1;
            app_rdy     = (n > t.cmd_dly);
            app_wdf_rdy = (n > t.wdf_dly);
        end
        req_valid[t.r] = 1'b0;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        chk_int("txn_ready_latency", n, t.exp_n);
        chk_int("txn_app_en_cycles", en_c, t.exp_en);
        chk_int("txn_wren_cycles", wr_c, t.exp_wren);
    endtask

    task automatic rd_burst(input int cnt);
        logic [DW-1:0] d;
        logic          t;
        for (int i = 0; i < cnt; i++) begin
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
            app_rd_data       = d;
            app_rd_data_valid = 1'b1;
            if (model_tag_q.size() != 0) begin
                t = model_tag_q.pop_front();
                exp_rd_q.push_back({(2'b01 << t), d});
            end
            @(posedge sys_clk); #1;
        end
        app_rd_data_valid = 1'b0;
        repeat (2) begin
            @(posedge sys_clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, r0c, r1c, enc;
        bit seen0, got;
        logic [1:0] exp_seq [8];
        logic g;

        tbl[0] = '{r:1'b0, wr:1'b1, addr:28'h0000100, pat:8'hA5, mask:64'h0,
                   cmd_dly:0, wdf_dly:0, exp_n:2, exp_en:1, exp_wren:1};
        tbl[1] = '{r:1'b1, wr:1'b0, addr:28'h0000200, pat:8'h00, mask:64'h0,
                   cmd_dly:0, wdf_dly:0, exp_n:2, exp_en:1, exp_wren:0};
        tbl[2] = '{r:1'b0, wr:1'b1, addr:28'h0ABCDE0, pat:8'h5A, mask:64'h0,
                   cmd_dly:3, wdf_dly:0, exp_n:5, exp_en:4, exp_wren:1};
        tbl[3] = '{r:1'b1, wr:1'b1, addr:28'hFFFFFFF, pat:8'h3C, mask:64'h00000000_0000FFFF,
                   cmd_dly:0, wdf_dly:3, exp_n:5, exp_en:1, exp_wren:4};
        tbl[4] = '{r:1'b0, wr:1'b0, addr:28'h1234560, pat:8'h00, mask:64'h0,
                   cmd_dly:2, wdf_dly:0, exp_n:4, exp_en:3, exp_wren:0};
        tbl[5] = '{r:1'b1, wr:1'b1, addr:28'h7654320, pat:8'hC3, mask:64'hFFFFFFFF_FFFFFFFF,
                   cmd_dly:1, wdf_dly:2, exp_n:4, exp_en:2, exp_wren:3};

        sys_rst = 1'b1;
        init_calib_complete = 1'b1;
        req_valid = 2'b00; req_write = 2'b00;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0;
        #2;
        chk("reset_outputs", 576'({req_ready, rd_valid, rd_tag_err, app_en, app_wdf_wren,
                                   app_wdf_end, app_cmd, app_addr}), 576'(0));
        chk("reset_wdf_bus", {app_wdf_data, app_wdf_mask}, 576'(0));
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);
        rd_burst(2);
        chk_int("table_reads_returned", exp_rd_q.size(), 0);

        // Contention: both requesters read continuously
        for (int i = 0; i < 8; i++) begin
            g = mdl_rr ^ i[0];
            exp_cmd_q.push_back({3'b001, g ? 28'h0002000 : 28'h0001000});
            model_tag_q.push_back(g);
            exp_seq[i] = 2'b01 << g;
        end
        set_req(1'b0, 1'b0, 28'h0001000, 8'h00, 64'h0);
        set_req(1'b1, 1'b0, 28'h0002000, 8'h00, 64'h0);
        req_valid = 2'b11;
        n = 0; k = 0;
        while (k < 8 && n < 40) begin
            @(negedge sys_clk);
            n++;
            if (req_ready != 2'b00) begin
                chk("grant_order", 576'(req_ready), 576'(exp_seq[k]));
                k++;
            end
            @(posedge sys_clk); #1;
        end
        req_valid = 2'b00;
        chk_int("contention_cycles", n, 16);
        rd_burst(8);
        chk_int("contention_reads_returned", exp_rd_q.size(), 0);

        // Tag FIFO full: 16 outstanding reads from requester 1
        for (int i = 0; i < 16; i++)
            run_txn('{r:1'b1, wr:1'b0, addr:28'h0000300 + 28'(i), pat:8'h00, mask:64'h0,
                      cmd_dly:0, wdf_dly:0, exp_n:2, exp_en:1, exp_wren:0});
        exp_cmd_q.push_back({3'b000, 28'h0000400});
        exp_wdf_q.push_back({{64{8'h66}}, 64'h0F0F});
        set_req(1'b0, 1'b1, 28'h0000400, 8'h66, 64'h0F0F);
        set_req(1'b1, 1'b0, 28'h0000500, 8'h00, 64'h0);
        req_valid = 2'b11;
        r0c = 0; r1c = 0; enc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            r0c += int'(req_ready[0]);
            r1c += int'(req_ready[1]);
            enc += int'(app_en);
            seen0 = req_ready[0];
            @(posedge sys_clk); #1;
            if (seen0) req_valid[0] = 1'b0;
        end
        chk_int("full_write_granted", r0c, 1);
        chk_int("full_read_blocked", r1c, 0);
        chk_int("full_app_en_cycles", enc, 1);
        exp_cmd_q.push_back({3'b001, 28'h0000500});
        app_rd_data = {16{32'hDEADBEEF}};
        app_rd_data_valid = 1'b1;
        g = model_tag_q.pop_front();
        exp_rd_q.push_back({(2'b01 << g), {16{32'hDEADBEEF}}});
        @(posedge sys_clk); #1;
        app_rd_data_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge sys_clk);
            got = req_ready[1];
            @(posedge sys_clk); #1;
        end
        req_valid[1] = 1'b0;
        model_tag_q.push_back(1'b1);
        chk_int("full_read_released", int'(got), 1);
        rd_burst(16);
        chk_int("full_reads_returned", exp_rd_q.size(), 0);

        // Calibration gate
        init_calib_complete = 1'b0;
        set_req(1'b0, 1'b1, 28'h0000600, 8'h81, 64'h0);
        req_valid[0] = 1'b1;
        enc = 0; r0c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            enc += int'(app_en);
            r0c += int'(req_ready[0]);
            @(posedge sys_clk); #1;
        end
        chk_int("calib_gate_app_en", enc, 0);
        chk_int("calib_gate_ready", r0c, 0);
        exp_cmd_q.push_back({3'b000, 28'h0000600});
        exp_wdf_q.push_back({{64{8'h81}}, 64'h0});
        init_calib_complete = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge sys_clk);
            got = req_ready[0];
            @(posedge sys_clk); #1;
        end
        req_valid[0] = 1'b0;
        chk_int("calib_release_ready", int'(got), 1);

        // Orphan read data sets the sticky error
        @(negedge sys_clk);
        chk("tag_err_clear", 576'(rd_tag_err), 576'(1'b0));
        @(posedge sys_clk); #1;
        app_rd_data_valid = 1'b1;
        @(posedge sys_clk); #1;
        app_rd_data_valid = 1'b0;
        @(negedge sys_clk);
        chk("tag_err_set", 576'(rd_tag_err), 576'(1'b1));
        repeat (5) @(negedge sys_clk);
        chk("tag_err_sticky", 576'(rd_tag_err), 576'(1'b1));
        @(posedge sys_clk); #1;

        // Reset mid-ISSUE with a tag outstanding
        run_txn('{r:1'b1, wr:1'b0, addr:28'h0000800, pat:8'h00, mask:64'h0,
                  cmd_dly:0, wdf_dly:0, exp_n:2, exp_en:1, exp_wren:0});
        app_rdy = 1'b0;
        set_req(1'b0, 1'b0, 28'h0000900, 8'h00, 64'h0);
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge sys_clk);
            got = app_en;
            if (!got) begin
                @(posedge sys_clk); #1;
            end
        end
        chk_int("rst_issue_reached", int'(got), 1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("rst_async_outputs", 576'({req_ready, rd_valid, rd_tag_err, app_en, app_wdf_wren,
                                       app_wdf_end, app_cmd, app_addr}), 576'(0));
        model_tag_q.delete();
        req_valid = 2'b00;
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        app_rdy = 1'b1;
        enc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            enc += int'(app_en);
        end
        chk_int("rst_idle_app_en", enc, 0);
        @(posedge sys_clk); #1;
        app_rd_data_valid = 1'b1;
        @(posedge sys_clk); #1;
        app_rd_data_valid = 1'b0;
        @(negedge sys_clk);
        chk("rst_fifo_empty_err", 576'({rd_tag_err, rd_valid}), 576'(3'b100));
        @(posedge sys_clk); #1;
        run_txn('{r:1'b0, wr:1'b1, addr:28'h0000A00, pat:8'h99, mask:64'h1,
                  cmd_dly:0, wdf_dly:0, exp_n:2, exp_en:1, exp_wren:1});
        repeat (3) @(posedge sys_clk);
        #1;

        chk_int("final_cmd_queue", exp_cmd_q.size(), 0);
        chk_int("final_wdf_queue", exp_wdf_q.size(), 0);
        chk_int("final_rd_queue", exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
